// File: rtl/rtc_time_counter.sv
// rtc_time_counter
// BCD time-of-day counter with optional seconds, run/hold gating, validated load,
// 12/24-hour display conversion and registered hour/day rollover pulses.
// Internal state is always 24-hour BCD; 12-hour mode only reshapes the display.

module rtc_time_counter #(
    parameter bit HAS_SECONDS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_load,
    input  logic [3:0] i_ld_hr_ms,
    input  logic [3:0] i_ld_hr_ls,
    input  logic [3:0] i_ld_min_ms,
    input  logic [3:0] i_ld_min_ls,
    input  logic [3:0] i_ld_sec_ms,
    input  logic [3:0] i_ld_sec_ls,
    input  logic       i_hr12_mode,
    output logic [3:0] o_hr_ms,
    output logic [3:0] o_hr_ls,
    output logic [3:0] o_min_ms,
    output logic [3:0] o_min_ls,
    output logic [3:0] o_sec_ms,
    output logic [3:0] o_sec_ls,
    output logic       o_pm,
    output logic       o_load_err,
    output logic       o_hour_tick,
    output logic       o_day_tick
);

    logic [3:0] r_hr_ms, r_hr_ls, r_min_ms, r_min_ls, r_sec_ms, r_sec_ls;
    logic       r_load_err, r_hour_tick, r_day_tick;

    logic [3:0] w_nxt_hr_ms, w_nxt_hr_ls, w_nxt_min_ms, w_nxt_min_ls;
    logic [3:0] w_nxt_sec_ms, w_nxt_sec_ls;
    logic       w_min_carry, w_hour_roll, w_day_roll;
    logic       w_hr_ok, w_min_ok, w_sec_ok, w_ld_valid, w_advance;

    // Hours must be 00-23 with each digit BCD; seconds only matter when present.
    assign w_hr_ok    = ((i_ld_hr_ms <= 4'd1) && (i_ld_hr_ls <= 4'd9)) ||
                        ((i_ld_hr_ms == 4'd2) && (i_ld_hr_ls <= 4'd3));
    assign w_min_ok   = (i_ld_min_ms <= 4'd5) && (i_ld_min_ls <= 4'd9);
    assign w_sec_ok   = !HAS_SECONDS || ((i_ld_sec_ms <= 4'd5) && (i_ld_sec_ls <= 4'd9));
    assign w_ld_valid = w_hr_ok && w_min_ok && w_sec_ok;

    // A load in the same cycle swallows the tick rather than deferring it.
    assign w_advance  = i_tick && i_run && !i_load;

    // BCD ripple increment of the current time; also flags hour and day rollover.
    always_comb begin
        w_nxt_hr_ms  = r_hr_ms;
        w_nxt_hr_ls  = r_hr_ls;
        w_nxt_min_ms = r_min_ms;
        w_nxt_min_ls = r_min_ls;
        w_nxt_sec_ms = r_sec_ms;
        w_nxt_sec_ls = r_sec_ls;
        w_min_carry  = 1'b1;
        w_hour_roll  = 1'b0;
        w_day_roll   = 1'b0;

        if (HAS_SECONDS) begin
            w_min_carry = (r_sec_ls == 4'd9) && (r_sec_ms == 4'd5);
            if (r_sec_ls == 4'd9) begin
                w_nxt_sec_ls = 4'd0;
                if (r_sec_ms == 4'd5) begin
                    w_nxt_sec_ms = 4'd0;
                end else begin
                    w_nxt_sec_ms = r_sec_ms + 4'd1;
                end
            end else begin
                w_nxt_sec_ls = r_sec_ls + 4'd1;
            end
        end

        if (w_min_carry) begin
            if (r_min_ls == 4'd9) begin
                w_nxt_min_ls = 4'd0;
                if (r_min_ms == 4'd5) begin
                    w_nxt_min_ms = 4'd0;
                    w_hour_roll  = 1'b1;
                end else begin
                    w_nxt_min_ms = r_min_ms + 4'd1;
                end
            end else begin
                w_nxt_min_ls = r_min_ls + 4'd1;
            end
        end

        if (w_hour_roll) begin
            if ((r_hr_ms == 4'd2) && (r_hr_ls == 4'd3)) begin
                w_nxt_hr_ms = 4'd0;
                w_nxt_hr_ls = 4'd0;
                w_day_roll  = 1'b1;
            end else if (r_hr_ls == 4'd9) begin
                w_nxt_hr_ls = 4'd0;
                w_nxt_hr_ms = r_hr_ms + 4'd1;
            end else begin
                w_nxt_hr_ls = r_hr_ls + 4'd1;
            end
        end
    end

    // Time state and one-cycle status pulses; priority is reset, load, then tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hr_ms     <= 4'd0;
            r_hr_ls     <= 4'd0;
            r_min_ms    <= 4'd0;
            r_min_ls    <= 4'd0;
            r_sec_ms    <= 4'd0;
            r_sec_ls    <= 4'd0;
            r_load_err  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
        end else begin
            r_load_err  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
            if (i_load) begin
                if (w_ld_valid) begin
                    r_hr_ms  <= i_ld_hr_ms;
                    r_hr_ls  <= i_ld_hr_ls;
                    r_min_ms <= i_ld_min_ms;
                    r_min_ls <= i_ld_min_ls;
                    r_sec_ms <= HAS_SECONDS ? i_ld_sec_ms : 4'd0;
                    r_sec_ls <= HAS_SECONDS ? i_ld_sec_ls : 4'd0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (w_advance) begin
                r_hr_ms     <= w_nxt_hr_ms;
                r_hr_ls     <= w_nxt_hr_ls;
                r_min_ms    <= w_nxt_min_ms;
                r_min_ls    <= w_nxt_min_ls;
                r_sec_ms    <= w_nxt_sec_ms;
                r_sec_ls    <= w_nxt_sec_ls;
                r_hour_tick <= w_hour_roll;
                r_day_tick  <= w_day_roll;
            end
        end
    end

    // Hour display: 24h passes through; 12h maps 00->12 and 13..23 -> 01..11 in BCD.
    always_comb begin
        o_hr_ms = r_hr_ms;
        o_hr_ls = r_hr_ls;
        if (i_hr12_mode) begin
            if ((r_hr_ms == 4'd0) && (r_hr_ls == 4'd0)) begin
                o_hr_ms = 4'd1;
                o_hr_ls = 4'd2;
            end else if ((r_hr_ms == 4'd1) && (r_hr_ls >= 4'd3)) begin
                o_hr_ms = 4'd0;
                o_hr_ls = r_hr_ls - 4'd2;
            end else if ((r_hr_ms == 4'd2) && (r_hr_ls <= 4'd1)) begin
                o_hr_ms = 4'd0;
                o_hr_ls = r_hr_ls + 4'd8;
            end else if (r_hr_ms == 4'd2) begin
                o_hr_ms = 4'd1;
                o_hr_ls = r_hr_ls - 4'd2;
            end
        end
    end

    assign o_pm        = (r_hr_ms == 4'd2) || ((r_hr_ms == 4'd1) && (r_hr_ls >= 4'd2));
    assign o_min_ms    = r_min_ms;
    assign o_min_ls    = r_min_ls;
    assign o_sec_ms    = r_sec_ms;
    assign o_sec_ls    = r_sec_ls;
    assign o_load_err  = r_load_err;
    assign o_hour_tick = r_hour_tick;
    assign o_day_tick  = r_day_tick;

endmodule

// File: tb/tb_rtc_time_counter.sv
// tb_rtc_time_counter
// Drives a seconds-capable and a minutes-only counter with the same stimulus and
// compares both every cycle against an arithmetic time-of-day model, plus literal
// spot checks on the interesting corners.

module tb_rtc_time_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        run = 1'b1;
    logic        load = 1'b0;
    logic        hr12 = 1'b0;
    logic [23:0] ldVal = 24'h0;

    logic [3:0]  digA [6];
    logic [3:0]  digB [6];
    logic        pmA, errA, hourA, dayA;
    logic        pmB, errB, hourB, dayB;
    logic [27:0] vecA, vecB;

    int          assertCount = 0;
    int          failCount = 0;
    bit          checkEn = 1'b0;

    int          mSec = 0;
    int          mMin = 0;
    bit          mErrA = 0, mHourA = 0, mDayA = 0;
    bit          mErrB = 0, mHourB = 0, mDayB = 0;

    always #5 clk = ~clk;

    rtc_time_counter #(.HAS_SECONDS(1'b1)) dutSec (
        .clk(clk), .reset(reset), .i_tick(tick), .i_run(run), .i_load(load),
        .i_ld_hr_ms(ldVal[23:20]), .i_ld_hr_ls(ldVal[19:16]),
        .i_ld_min_ms(ldVal[15:12]), .i_ld_min_ls(ldVal[11:8]),
        .i_ld_sec_ms(ldVal[7:4]), .i_ld_sec_ls(ldVal[3:0]),
        .i_hr12_mode(hr12),
        .o_hr_ms(digA[0]), .o_hr_ls(digA[1]), .o_min_ms(digA[2]), .o_min_ls(digA[3]),
        .o_sec_ms(digA[4]), .o_sec_ls(digA[5]),
        .o_pm(pmA), .o_load_err(errA), .o_hour_tick(hourA), .o_day_tick(dayA)
    );

    rtc_time_counter #(.HAS_SECONDS(1'b0)) dutMin (
        .clk(clk), .reset(reset), .i_tick(tick), .i_run(run), .i_load(load),
        .i_ld_hr_ms(ldVal[23:20]), .i_ld_hr_ls(ldVal[19:16]),
        .i_ld_min_ms(ldVal[15:12]), .i_ld_min_ls(ldVal[11:8]),
        .i_ld_sec_ms(ldVal[7:4]), .i_ld_sec_ls(ldVal[3:0]),
        .i_hr12_mode(hr12),
        .o_hr_ms(digB[0]), .o_hr_ls(digB[1]), .o_min_ms(digB[2]), .o_min_ls(digB[3]),
        .o_sec_ms(digB[4]), .o_sec_ls(digB[5]),
        .o_pm(pmB), .o_load_err(errB), .o_hour_tick(hourB), .o_day_tick(dayB)
    );

    assign vecA = {digA[0], digA[1], digA[2], digA[3], digA[4], digA[5], pmA, errA, hourA, dayA};
    assign vecB = {digB[0], digB[1], digB[2], digB[3], digB[4], digB[5], pmB, errB, hourB, dayB};

    // Legal load: every digit BCD, hours at most 23, tens of minutes/seconds at most 5.
    function automatic bit ldOk(input logic [23:0] v, input bit withSec);
        int hMs = int'(v[23:20]);
        int hLs = int'(v[19:16]);
        bit ok;
        ok = (hMs <= 9) && (hLs <= 9) && (hMs * 10 + hLs <= 23) &&
             (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9);
        if (withSec) ok = ok && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
        return ok;
    endfunction

    function automatic int ldSeconds(input logic [23:0] v, input bit withSec);
        int s;
        s = (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
            (int'(v[15:12]) * 10 + int'(v[11:8])) * 60;
        if (withSec) s = s + int'(v[7:4]) * 10 + int'(v[3:0]);
        return s;
    endfunction

    // Expected output bundle from seconds-of-day and the display mode.
    function automatic logic [27:0] expVec(input int s, input bit h12,
                                           input bit le, input bit ht, input bit dt);
        int h = s / 3600;
        int m = (s / 60) % 60;
        int sc = s % 60;
        int dh = h;
        if (h12) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        return {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10),
                (h >= 12), le, ht, dt};
    endfunction

    // Reference model advances on the same edges as the DUTs.
    always @(posedge clk) begin
        if (reset) begin
            mSec <= 0; mMin <= 0;
            mErrA <= 0; mHourA <= 0; mDayA <= 0;
            mErrB <= 0; mHourB <= 0; mDayB <= 0;
        end else begin
            mErrA <= 0; mHourA <= 0; mDayA <= 0;
            mErrB <= 0; mHourB <= 0; mDayB <= 0;
            if (load) begin
                if (ldOk(ldVal, 1'b1)) mSec <= ldSeconds(ldVal, 1'b1);
                else mErrA <= 1;
                if (ldOk(ldVal, 1'b0)) mMin <= ldSeconds(ldVal, 1'b0) / 60;
                else mErrB <= 1;
            end else if (tick && run) begin
                mSec   <= (mSec + 1) % 86400;
                mHourA <= ((mSec + 1) % 3600) == 0;
                mDayA  <= ((mSec + 1) % 86400) == 0;
                mMin   <= (mMin + 1) % 1440;
                mHourB <= ((mMin + 1) % 60) == 0;
                mDayB  <= ((mMin + 1) % 1440) == 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        if (checkEn) begin
            checkOutput("modelSec", vecA, expVec(mSec, hr12, mErrA, mHourA, mDayA));
            checkOutput("modelMin", vecB, expVec(mMin * 60, hr12, mErrB, mHourB, mDayB));
        end
    end

    task automatic applyStimulus(input logic t, input logic l, input logic [23:0] v);
        @(negedge clk);
        tick  = t;
        load  = l;
        ldVal = v;
        @(posedge clk);
        #1;
        tick = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(0, 0, 24'h0);
        applyStimulus(0, 0, 24'h0);
        reset = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset_sec", vecA, 28'h0000000);
        checkOutput("reset_min", vecB, 28'h0000000);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 24'h0);
            applyStimulus(1, 0, 24'h0);
        end
        checkOutput("sixty_ticks_sec", vecA, 28'h0001000);
        checkOutput("sixty_ticks_min", vecB, 28'h0100002);

        applyStimulus(0, 1, 24'h235959);
        applyStimulus(1, 0, 24'h0);
        checkOutput("day_roll_sec", vecA, 28'h0000003);
        checkOutput("day_roll_min", vecB, 28'h0000003);
        applyStimulus(0, 0, 24'h0);
        checkOutput("day_pulse_end", vecA, 28'h0000000);

        applyStimulus(0, 1, 24'h095959);
        applyStimulus(1, 0, 24'h0);
        checkOutput("hour_09_10_sec", vecA, 28'h1000002);
        checkOutput("hour_09_10_min", vecB, 28'h1000002);

        applyStimulus(0, 1, 24'h195959);
        applyStimulus(1, 0, 24'h0);
        checkOutput("hour_19_20_sec", vecA, 28'h200000A);
        checkOutput("hour_19_20_min", vecB, 28'h200000A);
        applyStimulus(0, 0, 24'h0);

        applyStimulus(0, 1, 24'h240000);
        checkOutput("bad_hr24", vecA, 28'h200000C);
        applyStimulus(0, 1, 24'h126000);
        checkOutput("bad_min60", vecA, 28'h200000C);
        applyStimulus(0, 1, 24'h0A0000);
        checkOutput("bad_hrA_sec", vecA, 28'h200000C);
        checkOutput("bad_hrA_min", vecB, 28'h200000C);
        applyStimulus(0, 1, 24'h120060);
        checkOutput("bad_sec60_sec", vecA, 28'h200000C);
        checkOutput("sec60_ignored_min", vecB, 28'h1200008);

        applyStimulus(1, 1, 24'h123456);
        checkOutput("load_beats_tick_sec", vecA, 28'h1234568);
        checkOutput("load_beats_tick_min", vecB, 28'h1234008);

        run = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 24'h0);
        checkOutput("hold_sec", vecA, 28'h1234568);
        checkOutput("hold_min", vecB, 28'h1234008);
        run = 1'b1;

        hr12 = 1'b1;
        applyStimulus(0, 1, 24'h001500);
        checkOutput("h12_0015", vecA, 28'h1215000);
        applyStimulus(0, 1, 24'h120000);
        checkOutput("h12_1200", vecA, 28'h1200008);
        applyStimulus(0, 1, 24'h130500);
        checkOutput("h12_1305", vecA, 28'h0105008);
        applyStimulus(0, 1, 24'h235900);
        checkOutput("h12_2359", vecA, 28'h1159008);
        applyStimulus(0, 1, 24'h200000);
        checkOutput("h12_2000_sec", vecA, 28'h0800008);
        checkOutput("h12_2000_min", vecB, 28'h0800008);
        hr12 = 1'b0;
        #1;
        checkOutput("h24_immediate", vecA, 28'h2000008);

        hr12 = 1'b1;
        reset = 1'b1;
        applyStimulus(0, 1, 24'h123456);
        reset = 1'b0;
        checkOutput("reset_drops_load", vecA, 28'h1200000);

        applyStimulus(0, 1, 24'h225830);
        for (int i = 0; i < 6000; i++) begin
            if ((i % 97) == 0) hr12 = $urandom_range(0, 1);
            run = ($urandom_range(0, 9) != 0);
            applyStimulus(($urandom_range(0, 3) != 0), 1'b0, 24'h0);
        end

        checkEn = 1'b0;
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
